// File: rtl/video_luma_mode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : video_luma_mode_pipe
// Purpose  : 3-stage RGB -> luma display pipeline with per-frame mode,
//            threshold and luma statistics (mean via a sequential divider).
// Options  : define BINARY_HYST_EN for a hysteresis binary decision.
// Revision : 1.0 - initial release
// ============================================================================
module video_luma_mode_pipe #(
  parameter int DW     = 8,
  parameter int XW     = 12,
  parameter int KR     = 76,
  parameter int KG     = 150,
  parameter int KB     = 30,
  parameter int CNTW   = 22,
  parameter int SUMW   = 32,
  parameter int TH_RST = 40,
  parameter int HYST   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic [XW-1:0]     i_x,
  input  logic [XW-1:0]     i_y,
  input  logic [3*DW-1:0]   i_data,
  input  logic [2:0]        mode_req,
  input  logic [DW-1:0]     threshold_set,
  input  logic              auto_th_en,
  output logic [3*DW-1:0]   o_data,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [XW-1:0]     o_x,
  output logic [XW-1:0]     o_y,
  output logic              th_flag,
  output logic [DW-1:0]     frame_mean,
  output logic [CNTW-1:0]   frame_hi_cnt,
  output logic              stats_valid
);

  localparam int PW = DW + 8;
  localparam int CW = $clog2(SUMW + 1);
  localparam logic [PW-1:0]   c_kr   = PW'(KR);
  localparam logic [PW-1:0]   c_kg   = PW'(KG);
  localparam logic [PW-1:0]   c_kb   = PW'(KB);
  localparam logic [DW+1:0]   c_q1   = (DW+2)'(2**(DW-2));
  localparam logic [DW+1:0]   c_q3   = (DW+2)'(3 * 2**(DW-2));
  localparam logic [DW+1:0]   c_e1   = (DW+2)'(2**(DW-3));
  localparam logic [DW+1:0]   c_e7   = (DW+2)'(7 * 2**(DW-3));
  localparam logic [CW-1:0]   c_last = CW'(SUMW - 1);
  localparam logic [2:0] MD_GREY = 3'd1, MD_BIN = 3'd2, MD_STR = 3'd3, MD_INV = 3'd4;
  localparam logic [1:0] S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2;

  // Pipeline registers
  logic            hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
  logic [XW-1:0]   x1_q, y1_q, x2_q, y2_q;
  logic [3*DW-1:0] data1_q, data2_q;
  logic [PW-1:0]   pr_r_q, pr_g_q, pr_b_q;
  logic [DW-1:0]   luma2_q;
  logic [2:0]      mode_q;
  logic [DW-1:0]   th_q;
  logic [PW-1:0]   w_sum;
  logic            w_fs;

  // Frame start: rising edge of the raw vs against its 1-cycle delayed copy
  assign w_fs  = i_vs & ~vs1_q;
  assign w_sum = pr_r_q + pr_g_q + pr_b_q;

  // Stage 1 and 2: capture inputs with weighted products, then the luma sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q} <= '0;
      x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
      data1_q <= '0; data2_q <= '0; luma2_q <= '0;
      pr_r_q <= '0; pr_g_q <= '0; pr_b_q <= '0;
    end else begin
      {hs1_q, vs1_q, de1_q} <= {i_hs, i_vs, i_de};
      x1_q    <= i_x;
      y1_q    <= i_y;
      data1_q <= i_data;
      pr_r_q  <= PW'(i_data[3*DW-1:2*DW]) * c_kr;
      pr_g_q  <= PW'(i_data[2*DW-1:DW])   * c_kg;
      pr_b_q  <= PW'(i_data[DW-1:0])      * c_kb;
      {hs2_q, vs2_q, de2_q} <= {hs1_q, vs1_q, de1_q};
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      data2_q <= data1_q;
      luma2_q <= w_sum[PW-1:8];
    end
  end

  // Per-frame mode and threshold, frozen between frame starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      th_q   <= DW'(TH_RST);
    end else if (w_fs) begin
      mode_q <= mode_req;
      th_q   <= auto_th_en ? frame_mean : threshold_set;
    end
  end

  // Binary decision on the stage-2 luma
  logic w_flag;
`ifdef BINARY_HYST_EN
  logic          w_prev;
  logic [DW-1:0] w_lo;
  assign w_prev = (de2_q & ~o_de) ? 1'b0 : th_flag;
  assign w_lo   = (th_q > DW'(HYST)) ? (th_q - DW'(HYST)) : '0;
  assign w_flag = (luma2_q >= th_q) ? 1'b1 : ((luma2_q < w_lo) ? 1'b0 : w_prev);
`else
  assign w_flag = (luma2_q >= th_q);
`endif

  // Piecewise contrast stretch on a 2-bit-wider luma
  logic [DW+1:0] w_l_ext, w_t, w_st;
  assign w_l_ext = {2'b00, luma2_q};
  always_comb begin
    w_t  = '0;
    w_st = '0;
    if (w_l_ext < c_q1) begin
      w_st = w_l_ext >> 1;
    end else if (w_l_ext < c_q3) begin
      w_t  = w_l_ext - c_q1;
      w_st = c_e1 + ((w_t + (w_t << 1)) >> 1);
    end else begin
      w_t  = w_l_ext - c_q3;
      w_st = c_e7 + (w_t >> 1);
    end
  end

  // Mode selection for the stage-3 pixel
  logic [3*DW-1:0] w_out;
  always_comb begin
    case (mode_q)
      MD_GREY: w_out = {luma2_q, luma2_q, luma2_q};
      MD_BIN:  w_out = {(3*DW){w_flag}};
      MD_STR:  w_out = {w_st[DW-1:0], w_st[DW-1:0], w_st[DW-1:0]};
      MD_INV:  w_out = ~data2_q;
      default: w_out = data2_q;
    endcase
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0; {o_hs, o_vs, o_de, th_flag} <= '0; o_x <= '0; o_y <= '0;
    end else begin
      o_data  <= w_out;
      {o_hs, o_vs, o_de} <= {hs2_q, vs2_q, de2_q};
      o_x     <= x2_q;
      o_y     <= y2_q;
      th_flag <= w_flag;
    end
  end

  // Saturating luma statistics of the stage-2 stream
  logic [SUMW-1:0] lsum_q, w_lsum_nx;
  logic [SUMW:0]   w_lsum_add;
  logic [CNTW-1:0] pix_q, hi_q, w_pix_nx, w_hi_nx;
  assign w_lsum_add = {1'b0, lsum_q} + (SUMW+1)'(luma2_q);
  assign w_lsum_nx  = !de2_q ? lsum_q : (w_lsum_add[SUMW] ? '1 : w_lsum_add[SUMW-1:0]);
  assign w_pix_nx   = (de2_q && pix_q != '1) ? pix_q + 1'b1 : pix_q;
  assign w_hi_nx    = (de2_q && w_flag && hi_q != '1) ? hi_q + 1'b1 : hi_q;

  // Accumulators: cleared on frame start, their final values go to the divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsum_q <= '0; pix_q <= '0; hi_q <= '0;
    end else if (w_fs) begin
      lsum_q <= '0; pix_q <= '0; hi_q <= '0;
    end else begin
      lsum_q <= w_lsum_nx; pix_q <= w_pix_nx; hi_q <= w_hi_nx;
    end
  end

  // Divider FSM
  logic [1:0]      state_q, state_d;
  logic [SUMW-1:0] dvd_q;
  logic [CNTW-1:0] dsr_q, rem_q, hisnap_q;
  logic [CW-1:0]   cnt_q;
  logic            w_load, w_step, w_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a frame start always (re)starts the division
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_fs) state_d = S_DIV;
      S_DIV:   if (w_fs) state_d = S_DIV; else if (cnt_q == c_last) state_d = S_DONE;
      S_DONE:  state_d = w_fs ? S_DIV : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    w_load = w_fs;
    w_step = (state_q == S_DIV);
    w_done = (state_q == S_DONE);
  end

  // Restoring division step: quotient bits shift in where dividend bits leave
  logic [CNTW:0] w_rem_sh, w_rem_sub;
  logic          w_ge;
  assign w_rem_sh  = {rem_q, dvd_q[SUMW-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, dsr_q});
  assign w_rem_sub = w_rem_sh - {1'b0, dsr_q};

  // Divider datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0; dsr_q <= '0; rem_q <= '0; hisnap_q <= '0; cnt_q <= '0;
    end else if (w_load) begin
      dvd_q <= w_lsum_nx; dsr_q <= w_pix_nx; rem_q <= '0; hisnap_q <= w_hi_nx; cnt_q <= '0;
    end else if (w_step) begin
      dvd_q <= {dvd_q[SUMW-2:0], w_ge};
      rem_q <= w_ge ? w_rem_sub[CNTW-1:0] : w_rem_sh[CNTW-1:0];
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Published statistics: empty frame gives 0, large quotient saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_mean <= '0; frame_hi_cnt <= '0; stats_valid <= 1'b0;
    end else begin
      stats_valid <= w_done;
      if (w_done) begin
        frame_hi_cnt <= hisnap_q;
        if (dsr_q == '0)              frame_mean <= '0;
        else if (|dvd_q[SUMW-1:DW])   frame_mean <= '1;
        else                          frame_mean <= dvd_q[DW-1:0];
      end
    end
  end

endmodule
`default_nettype wire
